// File: rtl/pic_sync_pkg.sv
// Shared definitions for the synchronous interrupt controller.
// Holds the register addresses, the CTRL bit positions, the INTA
// handshake state type, the latched-grant record, and helpers for
// the circular priority scan. Indices are always 5 bits wide because
// the controller supports up to 32 request lines.
package pic_sync_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_VBASE = 3'd1;
  localparam logic [2:0] ADDR_IMR   = 3'd2;
  localparam logic [2:0] ADDR_EOI   = 3'd3;  // write side of address 3
  localparam logic [2:0] ADDR_IRR   = 3'd3;  // read side of address 3
  localparam logic [2:0] ADDR_ISR   = 3'd4;

  localparam int CTRL_LTIM = 0;
  localparam int CTRL_AEOI = 1;
  localparam int CTRL_ROT  = 2;
  localparam int CTRL_SMM  = 3;

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  // Winner captured in ACK1 and held through ACK2.
  typedef struct packed {
    logic       spur;
    logic [4:0] w;
  } grant_t;

  // Highest-priority set bit of v, walking n lines upward from lp+1.
  // Returns {found, index}.
  function automatic logic [5:0] prio_scan(input logic [31:0] v,
                                           input logic [4:0] lp,
                                           input int n);
    logic       found;
    logic [4:0] idx;
    int         p;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 32; i++) begin
      p = (int'(lp) + i) % n;
      if (i <= n && !found && v[p[4:0]]) begin
        found = 1'b1;
        idx   = p[4:0];
      end
    end
    return {found, idx};
  endfunction

  // Position of idx in the priority order; 0 is the highest.
  function automatic logic [4:0] prio_rank(input logic [4:0] idx,
                                           input logic [4:0] lp,
                                           input int n);
    int r;
    r = (int'(idx) - int'(lp) - 1 + 2 * n) % n;
    return r[4:0];
  endfunction

  function automatic logic [31:0] onehot(input logic [4:0] i);
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational priority resolver.
//   req    : pending requests (IRR)
//   isr    : in-service bits
//   imr    : mask bits
//   lp     : lowest-priority line; the order starts at lp+1
//   smm    : special mask mode, only unmasked ISR bits block
//   winner : highest-priority unmasked request
//   valid  : winner beats every blocking in-service level
module pic_prio_resolver import pic_sync_pkg::*; #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [4:0]         lp,
  input  logic               smm,
  output logic [4:0]         winner,
  output logic               valid
);

  logic [31:0] cand, blk;
  logic [5:0]  c_scan, b_scan;

  always_comb begin
    cand   = 32'(req & ~imr);
    blk    = smm ? 32'(isr & ~imr) : 32'(isr);
    c_scan = prio_scan(cand, lp, NUM_IRQ);
    b_scan = prio_scan(blk, lp, NUM_IRQ);
    winner = c_scan[4:0];
    // A request at the same level as the top ISR bit does not preempt it.
    valid  = c_scan[5] && (!b_scan[5] ||
             (prio_rank(c_scan[4:0], lp, NUM_IRQ) < prio_rank(b_scan[4:0], lp, NUM_IRQ)));
  end

endmodule

// File: rtl/pic_sync_ctrl.sv
// Synchronous 8259A-style interrupt controller.
//   CLK, RESET_n      : clock, synchronous active-low reset
//   IR                : asynchronous request lines (synchronised here)
//   CS_n/WR_n/RD_n    : register bus strobes, ADDR/DIN/DOUT register bus
//   INTA_n            : asynchronous acknowledge; two falling edges per vector
//   INT               : registered interrupt request to the CPU
//   VEC, VEC_VALID    : vector and its one-cycle qualifier
module pic_sync_ctrl import pic_sync_pkg::*; #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic               CS_n,
  input  logic               WR_n,
  input  logic               RD_n,
  input  logic [2:0]         ADDR,
  input  logic [NUM_IRQ-1:0] DIN,
  output logic [NUM_IRQ-1:0] DOUT,
  input  logic               INTA_n,
  output logic               INT,
  output logic [7:0]         VEC,
  output logic               VEC_VALID
);

  // One extra stage past the synchroniser holds the previous value for
  // edge detection.
  logic [SYNC_STAGES:0][NUM_IRQ-1:0] ir_pipe;
  logic [SYNC_STAGES:0]              inta_pipe;
  logic [NUM_IRQ-1:0] ir_s, ir_rise;
  logic               inta_fall;

  logic [3:0]         ctrl;
  logic [7:0]         vbase;
  logic [NUM_IRQ-1:0] imr, irr, isr, irr_nxt, isr_nxt;
  logic [4:0]         lp, lp_nxt;
  state_t             state, state_nxt;
  grant_t             grant;
  logic [4:0]         win;
  logic               win_vld;
  logic               wr, rd;
  logic [5:0]         eoi_top;

  assign ir_s      = ir_pipe[SYNC_STAGES-1];
  assign ir_rise   = ir_pipe[SYNC_STAGES-1] & ~ir_pipe[SYNC_STAGES];
  assign inta_fall = inta_pipe[SYNC_STAGES] & ~inta_pipe[SYNC_STAGES-1];
  assign wr        = !CS_n && !WR_n;
  assign rd        = !CS_n && !RD_n;

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req(irr), .isr(isr), .imr(imr), .lp(lp), .smm(ctrl[CTRL_SMM]),
    .winner(win), .valid(win_vld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inta_fall) state_nxt = ACK1;
      ACK1:    state_nxt = WAIT2;
      WAIT2:   if (inta_fall) state_nxt = ACK2;
      ACK2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // IRR/ISR/LP update. Order matters: ACK1 set, then AEOI clear, then a
  // bus EOI, so an EOI landing in ACK1 sees the freshly set bit.
  always_comb begin
    irr_nxt = irr;
    isr_nxt = isr;
    lp_nxt  = lp;
    eoi_top = '0;
    if (ctrl[CTRL_LTIM]) begin
      irr_nxt = ir_s;
    end else begin
      irr_nxt = irr | ir_rise;
      if (wr && ADDR == ADDR_CTRL) irr_nxt = '0;
    end
    if (state == ACK1 && win_vld) begin
      isr_nxt = isr_nxt | NUM_IRQ'(onehot(win));
      // Clearing after the OR drops a coincident edge on the granted line.
      if (!ctrl[CTRL_LTIM]) irr_nxt = irr_nxt & ~NUM_IRQ'(onehot(win));
    end
    if (state == ACK2 && ctrl[CTRL_AEOI] && !grant.spur) begin
      isr_nxt = isr_nxt & ~NUM_IRQ'(onehot(grant.w));
      if (ctrl[CTRL_ROT]) lp_nxt = grant.w;
    end
    if (wr && ADDR == ADDR_EOI) begin
      if (DIN[7]) begin
        if (int'(DIN[4:0]) < NUM_IRQ) begin
          isr_nxt = isr_nxt & ~NUM_IRQ'(onehot(DIN[4:0]));
          if (ctrl[CTRL_ROT]) lp_nxt = DIN[4:0];
        end
      end else begin
        eoi_top = prio_scan(32'(isr_nxt), lp, NUM_IRQ);
        if (eoi_top[5]) begin
          isr_nxt = isr_nxt & ~NUM_IRQ'(onehot(eoi_top[4:0]));
          if (ctrl[CTRL_ROT]) lp_nxt = eoi_top[4:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      ir_pipe   <= '0;
      inta_pipe <= '0;
      state     <= IDLE;
      ctrl      <= '0;
      vbase     <= '0;
      imr       <= '1;
      irr       <= '0;
      isr       <= '0;
      lp        <= 5'(NUM_IRQ - 1);
      grant     <= '0;
      INT       <= 1'b0;
      VEC       <= '0;
      VEC_VALID <= 1'b0;
      DOUT      <= '0;
    end else begin
      ir_pipe   <= {ir_pipe[SYNC_STAGES-1:0], IR};
      inta_pipe <= {inta_pipe[SYNC_STAGES-1:0], INTA_n};
      state     <= state_nxt;
      irr       <= irr_nxt;
      isr       <= isr_nxt;
      lp        <= lp_nxt;
      if (wr) begin
        case (ADDR)
          ADDR_CTRL:  ctrl  <= DIN[3:0];
          ADDR_VBASE: vbase <= DIN[7:0];
          ADDR_IMR:   imr   <= DIN;
          default:    ;
        endcase
      end
      // No serviceable request in ACK1 means a spurious acknowledge that
      // reports the lowest line without touching ISR.
      if (state == ACK1)
        grant <= '{spur: !win_vld, w: (win_vld ? win : 5'(NUM_IRQ - 1))};
      INT       <= win_vld && (state == IDLE);
      VEC_VALID <= (state_nxt == ACK2);
      if (state_nxt == ACK2) VEC <= vbase + 8'(grant.w);
      if (rd) begin
        case (ADDR)
          ADDR_CTRL:  DOUT <= NUM_IRQ'(ctrl);
          ADDR_VBASE: DOUT <= NUM_IRQ'(vbase);
          ADDR_IMR:   DOUT <= imr;
          ADDR_IRR:   DOUT <= irr;
          ADDR_ISR:   DOUT <= isr;
          default:    DOUT <= '0;
        endcase
      end else begin
        DOUT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pic_sync_ctrl.sv
// Bench for pic_sync_ctrl with 16 lines: directed scenarios followed by
// randomised edge-mode rounds against a transaction-level priority model.
module tb_pic_sync_ctrl;
  import pic_sync_pkg::*;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         RESET_n = 1'b0;
  logic [N-1:0] IR = '0;
  logic         CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1;
  logic [2:0]   ADDR = '0;
  logic [N-1:0] DIN = '0;
  logic [N-1:0] DOUT;
  logic         INTA_n = 1'b1;
  logic         INT;
  logic [7:0]   VEC;
  logic         VEC_VALID;

  pic_sync_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(2)) dut (
    .CLK(clk), .RESET_n(RESET_n), .IR(IR), .CS_n(CS_n), .WR_n(WR_n),
    .RD_n(RD_n), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .INTA_n(INTA_n),
    .INT(INT), .VEC(VEC), .VEC_VALID(VEC_VALID)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int vv_cnt = 0;
  logic [7:0] last_vec = '0;

  always @(negedge clk) if (VEC_VALID) begin vv_cnt++; last_vec = VEC; end

  // Reference model state
  logic [N-1:0] m_irr, m_isr, m_imr;
  logic [7:0]   m_vbase;
  bit           m_ltim, m_aeoi, m_rot, m_smm;
  int           m_lp;

  logic [7:0]   v, ev;
  logic [N-1:0] rdv, mask, pulse;
  logic [3:0]   ctrl_v;
  int           ns, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_imr = '1; m_vbase = '0; m_lp = N - 1;
    m_ltim = 0; m_aeoi = 0; m_rot = 0; m_smm = 0;
  endtask

  function automatic int rank(input int i);
    return (i - m_lp - 1 + 2 * N) % N;
  endfunction

  // Lowest-rank set bit, -1 when none.
  function automatic int best(input logic [N-1:0] x);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (x[i] && (b < 0 || rank(i) < rank(b))) b = i;
    return b;
  endfunction

  function automatic int m_winner();
    int c = best(m_irr & ~m_imr);
    int t = best(m_smm ? (m_isr & ~m_imr) : m_isr);
    if (c < 0) return -1;
    if (t >= 0 && rank(c) >= rank(t)) return -1;
    return c;
  endfunction

  task automatic model_ack(output logic [7:0] e);
    int w = m_winner();
    if (w < 0) e = m_vbase + 8'(N - 1);
    else begin
      e = m_vbase + 8'(w);
      m_isr[w] = 1'b1;
      if (!m_ltim) m_irr[w] = 1'b0;
      if (m_aeoi) begin m_isr[w] = 1'b0; if (m_rot) m_lp = w; end
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [N-1:0] d);
    CS_n = 0; WR_n = 0; ADDR = a; DIN = d;
    tick();
    CS_n = 1; WR_n = 1; DIN = '0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [N-1:0] d);
    CS_n = 0; RD_n = 0; ADDR = a;
    tick();
    d = DOUT;
    CS_n = 1; RD_n = 1;
  endtask

  task automatic set_ctrl(input logic [3:0] c);
    reg_wr(ADDR_CTRL, N'(c));
    m_ltim = c[0]; m_aeoi = c[1]; m_rot = c[2]; m_smm = c[3]; m_irr = '0;
  endtask

  task automatic pulse_ir(input logic [N-1:0] b);
    IR = b; repeat (2) tick();
    IR = '0; repeat (5) tick();
    m_irr = m_irr | b;
  endtask

  task automatic eoi(input bit spec, input int lvl);
    int t;
    reg_wr(ADDR_EOI, N'({spec, 2'b00, 5'(lvl)}));
    tick();
    if (spec) begin
      if (lvl < N) begin m_isr[lvl] = 1'b0; if (m_rot) m_lp = lvl; end
    end else begin
      t = best(m_isr);
      if (t >= 0) begin m_isr[t] = 1'b0; if (m_rot) m_lp = t; end
    end
  endtask

  task automatic hs(output logic [7:0] vo, output int n);
    int c0;
    c0 = vv_cnt;
    INTA_n = 0; repeat (4) tick(); INTA_n = 1; repeat (4) tick();
    INTA_n = 0; repeat (4) tick(); INTA_n = 1; repeat (4) tick();
    vo = last_vec; n = vv_cnt - c0;
  endtask

  // Handshake and compare; directed steps give the vector explicitly.
  task automatic ack(input string tag, input logic [7:0] exp, input bit use_model);
    logic [7:0] e;
    logic [7:0] got;
    int n;
    model_ack(e);
    hs(got, n);
    chk(tag, got, use_model ? e : exp);
    chk({tag, "_strobes"}, n, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    RESET_n = 1;
    tick();

    // 1: reset state, basic vector
    chk("rst_int", INT, 0);
    chk("rst_vec", VEC, 0);
    chk("rst_vv", VEC_VALID, 0);
    chk("rst_dout", DOUT, 0);
    reg_rd(ADDR_IMR, rdv); chk("rst_imr", rdv, 16'hFFFF);
    reg_rd(ADDR_ISR, rdv); chk("rst_isr", rdv, 0);
    reg_wr(ADDR_VBASE, 16'h20); m_vbase = 8'h20;
    reg_wr(ADDR_IMR, '0); m_imr = '0;
    IR[3] = 1'b1;
    repeat (3) tick();
    chk("int_k2", INT, 0);
    tick();
    chk("int_k3", INT, 1);
    IR = '0; m_irr[3] = 1'b1;
    repeat (4) tick();
    ack("vec_ir3", 8'h23, 0);
    reg_rd(ADDR_ISR, rdv); chk("isr_ir3", rdv, 16'h0008);
    eoi(0, 0);
    reg_rd(ADDR_ISR, rdv); chk("isr_eoi", rdv, 0);

    // 2: nesting
    pulse_ir(16'h0020);
    ack("vec_ir5", 8'h25, 0);
    pulse_ir(16'h0004);
    chk("nest_int2", INT, 1);
    ack("vec_ir2", 8'h22, 0);
    reg_rd(ADDR_ISR, rdv); chk("isr_nest", rdv, 16'h0024);
    pulse_ir(16'h0040);
    chk("nest_int6_blk", INT, 0);
    eoi(0, 0); tick();
    chk("nest_int_after1", INT, 0);
    reg_rd(ADDR_ISR, rdv); chk("isr_eoi1", rdv, 16'h0020);
    eoi(0, 0); tick();
    chk("nest_int_after2", INT, 1);
    ack("vec_ir6", 8'h26, 0);
    eoi(0, 0);

    // 3: rotation
    set_ctrl(4'b0100);
    pulse_ir(16'h0003);
    ack("rot_ir0", 8'h20, 0);
    eoi(0, 0);
    pulse_ir(16'h0001);
    ack("rot_ir1", 8'h21, 0);
    eoi(0, 0);
    ack("rot_ir0b", 8'h20, 0);
    eoi(0, 0);

    // 4: spurious in level mode
    set_ctrl(4'b0001);
    IR[4] = 1'b1; repeat (5) tick();
    chk("lvl_int", INT, 1);
    IR = '0; repeat (5) tick();
    chk("lvl_int_drop", INT, 0);
    ack("spur_vec", 8'h2F, 0);
    reg_rd(ADDR_ISR, rdv); chk("spur_isr", rdv, 0);

    // 5: auto-EOI
    set_ctrl(4'b0010);
    pulse_ir(16'h1000);
    ack("aeoi_vec", 8'h2C, 0);
    reg_rd(ADDR_ISR, rdv); chk("aeoi_isr", rdv, 0);

    // 6: reset during WAIT2
    set_ctrl(4'b0000);
    pulse_ir(16'h0080);
    INTA_n = 0; repeat (4) tick(); INTA_n = 1; repeat (2) tick();
    RESET_n = 0; repeat (2) tick(); RESET_n = 1; tick();
    model_reset();
    chk("wrst_int", INT, 0);
    reg_rd(ADDR_ISR, rdv); chk("wrst_isr", rdv, 0);
    reg_rd(ADDR_IMR, rdv); chk("wrst_imr", rdv, 16'hFFFF);
    ack("wrst_spur", 8'h0F, 0);

    // Randomised edge-mode rounds
    reg_wr(ADDR_VBASE, N'(8'($urandom))); m_vbase = 8'(DIN);
    reg_rd(ADDR_VBASE, rdv); m_vbase = 8'(rdv);
    reg_wr(ADDR_IMR, '0); m_imr = '0;
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        ctrl_v = {3'($urandom_range(0, 7)), 1'b0};
        set_ctrl(ctrl_v);
      end
      if ($urandom_range(0, 1) == 1) begin
        mask = N'($urandom) & N'($urandom);
        reg_wr(ADDR_IMR, mask); m_imr = mask;
      end
      pulse = N'($urandom) & N'($urandom) & N'($urandom);
      pulse_ir(pulse);
      chk("rnd_int", INT, (m_winner() >= 0) ? 1 : 0);
      ack("rnd_vec", 8'h00, 1);
      reg_rd(ADDR_ISR, rdv); chk("rnd_isr", rdv, m_isr);
      reg_rd(ADDR_IRR, rdv); chk("rnd_irr", rdv, m_irr);
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 1) eoi(1, $urandom_range(0, 19));
        else eoi(0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_sync_ctrl.md
Name: pic_sync_ctrl

Overview:
- Fully synchronous, parametrised successor of the 8259A-style interrupt controller.
- Channel count is configurable up to 32.
- Register set: IRR/IMR/ISR, fully nested priority with rotation, edge or level triggering, auto-EOI and special mask mode.
- A clocked two-pulse INTA handshake FSM returns an 8-bit vector; the block sits between peripheral IRQ lines and the CPU bus.

Parameters:
NUM_IRQ, 8, number of request lines; legal 8..32; also the register data width.
SYNC_STAGES, 2, synchroniser depth on IR and INTA_n; legal 2..3.

Ports:
CLK  in  1  system clock; all state on rising edge.
RESET_n  in  1  synchronous, active-low reset.
IR  in  NUM_IRQ  asynchronous interrupt request lines.
CS_n  in  1  chip select, active low.
WR_n  in  1  write strobe, active low, sampled synchronously.
RD_n  in  1  read strobe, active low.
ADDR  in  3  register address.
DIN  in  NUM_IRQ  write data.
DOUT  out  NUM_IRQ  read data; 0 when not reading.
INTA_n  in  1  interrupt acknowledge, asynchronous, active low.
INT  out  1  interrupt request to CPU, registered.
VEC  out  8  interrupt vector.
VEC_VALID  out  1  one-cycle strobe qualifying VEC.

Behaviour:
- Reset, applied in any state:
  - CTRL=0, VBASE=0, IMR=all 1s, IRR=0, ISR=0.
  - Lowest-priority pointer LP=NUM_IRQ-1, so IR0 is highest.
  - FSM=IDLE; INT=0, VEC=0, VEC_VALID=0, DOUT=0; synchroniser flops cleared.
  - A handshake interrupted by reset is abandoned; no ISR bit survives.
- Register map, write when CS_n=0 and WR_n=0, one write per cycle while low:
  - 0 CTRL: [0] LTIM (1=level), [1] AEOI, [2] ROT (rotate on EOI), [3] SMM.
  - 1 VBASE: [7:0].
  - 2 IMR.
  - 3 EOI: [7]=specific, [4:0]=level; write only. Nonspecific clears the highest-priority set ISR bit. Specific clears ISR[level]; level >= NUM_IRQ is ignored. With ROT=1, LP is set to the cleared level.
  - 4 IRR/ISR select: read returns IRR at 3 and ISR at 4.
  - 5–7: reserved; writes ignored, reads return 0.
- Reads: when CS_n=0 and RD_n=0, DOUT is registered with a 1-cycle latency.
- IRR:
  - Edge mode: a set bit requires a 0→1 transition of the synchronised IR. The bit is cleared at ACK1 for the granted line, or when LTIM is written.
  - Level mode: IRR = synchronised IR.
- Priority resolution:
  - Priority order is circular starting at LP+1 mod NUM_IRQ.
  - Candidate set: IRR & ~IMR.
  - Without SMM, a candidate is serviceable only if it has strictly higher priority than the highest set ISR bit.
  - With SMM, only ISR bits whose IMR bit is 0 block.
  - Ties are impossible because the priority order is strict.
- INT:
  - Registered: INT = serviceable request exists AND FSM==IDLE.
  - An IR rising sampled at edge k gives INT=1 at edge k+SYNC_STAGES+1.
  - INT drops when the FSM leaves IDLE, and also if the request is masked or withdrawn (level mode) before ACK1.
- INTA FSM, driven by falling edges of synchronised INTA_n:
  - IDLE: on a falling edge → ACK1.
  - ACK1 (one cycle):
    - Latch the winner W. If none exists, W=NUM_IRQ-1 and the request is flagged spurious.
    - If not spurious, set ISR[W] and clear the edge-mode IRR bit.
    - Priority state is frozen until IDLE.
    - Then → WAIT2.
  - WAIT2: on the next falling edge → ACK2.
  - ACK2:
    - VEC=(VBASE+W) mod 256 with VEC_VALID=1 for this cycle.
    - If AEOI and not spurious, clear ISR[W] and rotate LP=W when ROT=1.
    - Then → IDLE.
- Simultaneous events:
  - An EOI write during ACK1 is applied after the ISR set, in the same cycle.
  - An IR edge on the line being granted in ACK1 is lost (clear wins).
  - A register write in WAIT2 takes effect immediately, but W is already latched.

Decomposition:
- Package pic_sync_pkg holds:
  - Address constants ADDR_CTRL..ADDR_ISR.
  - CTRL bit indices.
  - FSM state enum: IDLE, ACK1, WAIT2, ACK2.
  - A function for the circular priority scan.
- One sub-module: pic_prio_resolver (combinational). Inputs: request, ISR, IMR, LP, SMM. Outputs: winner index, valid.

Test Plan:
1. Reset, then read IMR → all 1s. Write VBASE=0x20 and IMR=0. Pulse IR3 → INT at edge k+3. Two INTA_n pulses → VEC=0x23 with a 1-cycle VEC_VALID, ISR=0x08.
2. Nesting: with IR5 in service, raise IR2 → INT=1 and vector for 2 taken. Raise IR6 → INT stays 0 until two nonspecific EOIs clear ISR bits 2 then 5.
3. Rotation: ROT=1, IR0 and IR1 both pending. Service IR0 then EOI → LP=0. The next grant is IR1, and IR0 re-raised is lowest priority.
4. Spurious: assert then drop IR4 (level mode) before INTA → VEC=VBASE+NUM_IRQ-1 and ISR unchanged.
5. AEOI=1, NUM_IRQ=16: IR12 handshake → VEC=VBASE+12 and ISR=0 after ACK2.
6. Apply RESET_n in WAIT2 → FSM=IDLE, ISR=0, INT=0, IMR=all 1s. A later INTA pair with no requests gives a spurious vector.
